// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width default, ALU operation
// codes, branch funct3 conditions and forwarding-select codes (the latter are
// also used by the forwarding unit, so the encodings must not change).
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ   = 3'b000,
        BR_NE   = 3'b001,
        BR_LT   = 3'b100,
        BR_GE   = 3'b101,
        BR_LTU  = 3'b110,
        BR_GEU  = 3'b111
    } br_cond_e;

    // 2'b11 is not a legal select; consumers treat it as FWD_EX.
    typedef enum logic [1:0] {
        FWD_EX  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/ex_stage_if.sv
// Execute-stage bus: ID/EX operands and control bundle, forwarding selects,
// write-back value, stall/flush, and the EX/MEM register outputs plus the
// combinational branch resolution.
//   slave  : modport used by ex_stage (consumes ID/EX, produces EX/MEM)
//   master : modport used by the surrounding pipeline / testbench
interface ex_stage_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic [1:0]      ForwardA;
    logic [1:0]      ForwardB;
    logic [XLEN-1:0] rs1_data_ex;
    logic [XLEN-1:0] rs2_data_ex;
    logic [XLEN-1:0] imm_ex;
    logic [XLEN-1:0] pc_ex;
    logic [3:0]      alu_ctrl_ex;
    logic            ALUSrc_ex;
    logic            Branch_ex;
    logic [2:0]      funct3_ex;
    logic [4:0]      rd_ex;
    logic            RegWrite_ex;
    logic            MemRead_ex;
    logic            MemWrite_ex;
    logic            MemtoReg_ex;
    logic            valid_ex;
    logic [XLEN-1:0] wb_data;
    logic            stall;
    logic            flush;

    logic [XLEN-1:0] alu_result_mem;
    logic [XLEN-1:0] store_data_mem;
    logic [4:0]      rd_mem;
    logic            RegWrite_mem;
    logic            MemRead_mem;
    logic            MemWrite_mem;
    logic            MemtoReg_mem;
    logic            valid_mem;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;

    modport slave (
        input  ForwardA, ForwardB, rs1_data_ex, rs2_data_ex, imm_ex, pc_ex,
               alu_ctrl_ex, ALUSrc_ex, Branch_ex, funct3_ex, rd_ex,
               RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, valid_ex,
               wb_data, stall, flush,
        output alu_result_mem, store_data_mem, rd_mem, RegWrite_mem,
               MemRead_mem, MemWrite_mem, MemtoReg_mem, valid_mem,
               branch_taken, branch_target
    );

    modport master (
        output ForwardA, ForwardB, rs1_data_ex, rs2_data_ex, imm_ex, pc_ex,
               alu_ctrl_ex, ALUSrc_ex, Branch_ex, funct3_ex, rd_ex,
               RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, valid_ex,
               wb_data, stall, flush,
        input  alu_result_mem, store_data_mem, rd_mem, RegWrite_mem,
               MemRead_mem, MemWrite_mem, MemtoReg_mem, valid_mem,
               branch_taken, branch_target
    );

endinterface

// File: rtl/ex_stage_alu.sv
// RV32I ALU, purely combinational.
//   a, b     : operands
//   alu_ctrl : operation code (alu_op_e); unknown codes yield 0
//   result   : operation result, add/sub wrap modulo 2^XLEN
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] result
);
    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I pipeline.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : ex_stage_if.slave -- ID/EX operands/control, forwarding
//                selects, wb_data, stall/flush in; EX/MEM register and
//                combinational branch_taken/branch_target out
// Operand muxes pick ID/EX, EX/MEM or WB values; the ALU result, forwarded
// store data and control bundle are registered into EX/MEM. A bubble always
// clears RegWrite_mem so the forwarding unit need not look at valid_mem.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    ex_stage_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            valid;
    } exmem_t;

    logic [XLEN-1:0] opnd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_out;
    logic            cond;
    exmem_t          exmem_q;
    exmem_t          load_val;

    // MEM-path forwarding reads the registered result, so during a stall the
    // held value keeps being forwarded.
    always_comb begin
        case (bus.ForwardA)
            FWD_MEM: opnd_a = exmem_q.alu_result;
            FWD_WB:  opnd_a = bus.wb_data;
            default: opnd_a = bus.rs1_data_ex;
        endcase
    end

    always_comb begin
        case (bus.ForwardB)
            FWD_MEM: fwd_b = exmem_q.alu_result;
            FWD_WB:  fwd_b = bus.wb_data;
            default: fwd_b = bus.rs2_data_ex;
        endcase
    end

    assign alu_b = bus.ALUSrc_ex ? bus.imm_ex : fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .a        (opnd_a),
        .b        (alu_b),
        .alu_ctrl (bus.alu_ctrl_ex),
        .result   (alu_out)
    );

    // Branch compare ignores ALUSrc: always register vs register.
    always_comb begin
        cond = 1'b0;
        case (bus.funct3_ex)
            BR_EQ:   cond = (opnd_a == fwd_b);
            BR_NE:   cond = (opnd_a != fwd_b);
            BR_LT:   cond = ($signed(opnd_a) <  $signed(fwd_b));
            BR_GE:   cond = ($signed(opnd_a) >= $signed(fwd_b));
            BR_LTU:  cond = (opnd_a <  fwd_b);
            BR_GEU:  cond = (opnd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign bus.branch_taken  = bus.valid_ex & bus.Branch_ex & cond;
    assign bus.branch_target = bus.pc_ex + bus.imm_ex;

    always_comb begin
        load_val            = '0;
        load_val.alu_result = alu_out;
        load_val.store_data = fwd_b;
        load_val.rd         = bus.rd_ex;
        load_val.reg_write  = bus.RegWrite_ex;
        load_val.mem_read   = bus.MemRead_ex;
        load_val.mem_write  = bus.MemWrite_ex;
        load_val.mem_to_reg = bus.MemtoReg_ex;
        load_val.valid      = 1'b1;
    end

    // Priority: flush, then stall (hold), then invalid input (bubble), else load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_q <= '0;
        end else if (bus.flush) begin
            exmem_q <= '0;
        end else if (!bus.stall) begin
            exmem_q <= bus.valid_ex ? load_val : '0;
        end
    end

    assign bus.alu_result_mem = exmem_q.alu_result;
    assign bus.store_data_mem = exmem_q.store_data;
    assign bus.rd_mem         = exmem_q.rd;
    assign bus.RegWrite_mem   = exmem_q.reg_write;
    assign bus.MemRead_mem    = exmem_q.mem_read;
    assign bus.MemWrite_mem   = exmem_q.mem_write;
    assign bus.MemtoReg_mem   = exmem_q.mem_to_reg;
    assign bus.valid_mem      = exmem_q.valid;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed steps from the test plan followed
// by randomized instructions, all checked against a behavioural model.
module tb_ex_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if #(.XLEN(32)) bus ();

    ex_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model of the EX/MEM register contents.
    logic [31:0] m_res, m_sd;
    logic [4:0]  m_rd;
    logic [4:0]  m_ctl;   // {RegWrite, MemRead, MemWrite, MemtoReg, valid}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = int'(b[4:0]);
        case (op)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << sh;
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> sh;
            4'b1101: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] regv,
                                        input logic [31:0] memv, input logic [31:0] wbv);
        if (sel == 2'b10) return memv;
        if (sel == 2'b01) return wbv;
        return regv;
    endfunction

    task automatic model_reset();
        m_res = '0; m_sd = '0; m_rd = '0; m_ctl = '0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".alu_result_mem"}, bus.alu_result_mem, m_res);
        chk({tag, ".store_data_mem"}, bus.store_data_mem, m_sd);
        chk({tag, ".rd_mem"}, 32'(bus.rd_mem), 32'(m_rd));
        chk({tag, ".ctl_mem"},
            32'({bus.RegWrite_mem, bus.MemRead_mem, bus.MemWrite_mem, bus.MemtoReg_mem, bus.valid_mem}),
            32'(m_ctl));
    endtask

    task automatic idle();
        bus.ForwardA = 2'b00; bus.ForwardB = 2'b00;
        bus.rs1_data_ex = '0; bus.rs2_data_ex = '0; bus.imm_ex = '0; bus.pc_ex = '0;
        bus.alu_ctrl_ex = 4'b0000; bus.ALUSrc_ex = 1'b0; bus.Branch_ex = 1'b0;
        bus.funct3_ex = 3'b010; bus.rd_ex = '0;
        bus.RegWrite_ex = 1'b0; bus.MemRead_ex = 1'b0; bus.MemWrite_ex = 1'b0;
        bus.MemtoReg_ex = 1'b0; bus.valid_ex = 1'b0;
        bus.wb_data = '0; bus.stall = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        idle();
        bus.alu_ctrl_ex = op; bus.rs1_data_ex = a; bus.rs2_data_ex = b;
        bus.rd_ex = rd; bus.RegWrite_ex = 1'b1; bus.valid_ex = 1'b1;
    endtask

    // Inputs are already applied; check combinational outputs, clock once,
    // then check the EX/MEM register against the model.
    task automatic step(input string tag);
        logic [31:0] a, fb, bb, res;
        logic        taken;
        #1;
        a  = fwd(bus.ForwardA, bus.rs1_data_ex, m_res, bus.wb_data);
        fb = fwd(bus.ForwardB, bus.rs2_data_ex, m_res, bus.wb_data);
        bb = bus.ALUSrc_ex ? bus.imm_ex : fb;
        res = ref_alu(bus.alu_ctrl_ex, a, bb);
        taken = bus.valid_ex & bus.Branch_ex & ref_cond(bus.funct3_ex, a, fb);
        chk({tag, ".branch_taken"}, 32'(bus.branch_taken), 32'(taken));
        chk({tag, ".branch_target"}, bus.branch_target, bus.pc_ex + bus.imm_ex);
        @(posedge clk);
        if (bus.flush || (!bus.stall && !bus.valid_ex)) begin
            model_reset();
        end else if (!bus.stall) begin
            m_res = res; m_sd = fb; m_rd = bus.rd_ex;
            m_ctl = {bus.RegWrite_ex, bus.MemRead_ex, bus.MemWrite_ex, bus.MemtoReg_ex, 1'b1};
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        logic [31:0] frozen;
        idle();
        model_reset();

        // Reset holds everything at zero even with a valid instruction present.
        rst_n = 1'b0;
        alu_op(4'b0000, 32'd5, 32'd7, 5'd3);
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("add5_7");
        chk("add5_7.value", bus.alu_result_mem, 32'd12);
        chk("add5_7.rd", 32'(bus.rd_mem), 32'd3);
        chk("add5_7.regwrite_valid", 32'({bus.RegWrite_mem, bus.valid_mem}), 32'd3);

        // Forwarding from EX/MEM and from WB.
        alu_op(4'b0000, 32'd10, 32'd20, 5'd1);
        step("add10_20");
        alu_op(4'b1000, 32'hDEAD_BEEF, 32'd4, 5'd2);
        bus.ForwardA = 2'b10;
        step("sub_fwd_mem");
        chk("sub_fwd_mem.value", bus.alu_result_mem, 32'd26);
        alu_op(4'b0111, 32'h0000_0F0F, 32'h1234_5678, 5'd4);
        bus.ForwardB = 2'b01; bus.wb_data = 32'hFFFF_FFFF;
        step("and_fwd_wb");
        chk("and_fwd_wb.value", bus.alu_result_mem, 32'h0000_0F0F);
        alu_op(4'b0000, 32'd9, 32'd1, 5'd4);
        bus.ForwardA = 2'b11;
        step("fwd_11_as_00");

        // ALU edge cases.
        alu_op(4'b1101, 32'h8000_0000, 32'd31, 5'd5);
        step("sra31");
        chk("sra31.value", bus.alu_result_mem, 32'hFFFF_FFFF);
        alu_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd5);
        step("slt");
        chk("slt.value", bus.alu_result_mem, 32'd1);
        alu_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd5);
        step("sltu");
        chk("sltu.value", bus.alu_result_mem, 32'd0);
        alu_op(4'b0000, 32'hFFFF_FFFF, 32'd1, 5'd5);
        step("add_wrap");
        chk("add_wrap.value", bus.alu_result_mem, 32'd0);
        alu_op(4'b1111, 32'h1234_5678, 32'h0F0F_0F0F, 5'd5);
        step("code1111");
        chk("code1111.value", bus.alu_result_mem, 32'd0);

        // Branch resolution: BLT -5 < 3.
        alu_op(4'b0000, 32'd0, 32'd3, 5'd0);
        bus.RegWrite_ex = 1'b0; bus.Branch_ex = 1'b1; bus.funct3_ex = 3'b100;
        bus.ForwardA = 2'b01; bus.wb_data = 32'hFFFF_FFFB;
        bus.pc_ex = 32'h100; bus.imm_ex = 32'h20;
        #1;
        chk("blt.taken", 32'(bus.branch_taken), 32'd1);
        chk("blt.target", bus.branch_target, 32'h120);
        step("blt");
        bus.valid_ex = 1'b0;
        #1;
        chk("blt_invalid.taken", 32'(bus.branch_taken), 32'd0);
        step("blt_invalid");

        // Stall holds the register for three cycles while inputs change.
        alu_op(4'b0110, 32'h00F0_0000, 32'h0000_000F, 5'd7);
        bus.MemtoReg_ex = 1'b1;
        step("pre_stall");
        frozen = bus.alu_result_mem;
        for (int i = 0; i < 3; i++) begin
            alu_op(4'b0000, $urandom, $urandom, 5'(i + 10));
            bus.ForwardA = 2'b10;
            bus.stall = 1'b1;
            step("stall");
        end
        chk("stall.frozen", bus.alu_result_mem, 32'h00F0_000F);
        chk("stall.frozen_prev", bus.alu_result_mem, frozen);

        // Reset asserted mid-stall clears immediately without a clock edge.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("reset_mid_stall");
        @(negedge clk);
        rst_n = 1'b1;

        // Flush beats stall.
        alu_op(4'b0000, 32'd100, 32'd1, 5'd8);
        step("pre_flush");
        alu_op(4'b0000, 32'd3, 32'd4, 5'd9);
        bus.stall = 1'b1; bus.flush = 1'b1;
        step("flush_stall");
        chk("flush_stall.valid_regwrite", 32'({bus.valid_mem, bus.RegWrite_mem}), 32'd0);

        // Invalid instruction without stall loads a bubble.
        alu_op(4'b0000, 32'd100, 32'd1, 5'd8);
        step("pre_bubble");
        alu_op(4'b0000, 32'd3, 32'd4, 5'd9);
        bus.valid_ex = 1'b0;
        step("bubble");
        chk("bubble.valid_regwrite", 32'({bus.valid_mem, bus.RegWrite_mem}), 32'd0);

        // Store path: address from immediate, data forwarded from EX/MEM.
        alu_op(4'b0000, 32'h0000_ABCD, 32'd0, 5'd6);
        step("pre_store");
        alu_op(4'b0000, 32'h0000_1000, 32'h5555_5555, 5'd0);
        bus.RegWrite_ex = 1'b0; bus.MemWrite_ex = 1'b1;
        bus.ALUSrc_ex = 1'b1; bus.imm_ex = 32'd8; bus.ForwardB = 2'b10;
        step("store");
        chk("store.addr", bus.alu_result_mem, 32'h0000_1008);
        chk("store.data", bus.store_data_mem, 32'h0000_ABCD);

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            bus.ForwardA    = 2'($urandom);
            bus.ForwardB    = 2'($urandom);
            bus.rs1_data_ex = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            bus.rs2_data_ex = ($urandom_range(0, 3) == 0) ? bus.rs1_data_ex : $urandom;
            bus.imm_ex      = $urandom;
            bus.pc_ex       = $urandom;
            bus.alu_ctrl_ex = 4'($urandom);
            bus.ALUSrc_ex   = 1'($urandom);
            bus.Branch_ex   = 1'($urandom);
            bus.funct3_ex   = 3'($urandom);
            bus.rd_ex       = 5'($urandom);
            bus.RegWrite_ex = 1'($urandom);
            bus.MemRead_ex  = 1'($urandom);
            bus.MemWrite_ex = 1'($urandom);
            bus.MemtoReg_ex = 1'($urandom);
            bus.valid_ex    = ($urandom_range(0, 3) != 0);
            bus.wb_data     = $urandom;
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.flush       = ($urandom_range(0, 7) == 0);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I pipeline, sitting directly downstream of the forwarding unit. It applies `ForwardA`/`ForwardB` to pick ALU operands from the ID/EX register, its own EX/MEM result, or the WB write-back value. It evaluates the ALU and branch condition, and registers the result plus control bundle into the EX/MEM pipeline register with stall and flush support. Its `rd_mem`/`RegWrite_mem` outputs feed back into the forwarding unit.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous and active-low
- `ForwardA`, `ForwardB`  in  2 each  operand select: 00 ID/EX, 10 EX/MEM, 01 WB; 11 treated as 00
- `rs1_data_ex`, `rs2_data_ex`, `imm_ex`, `pc_ex`  in  XLEN each  ID/EX operands
- `alu_ctrl_ex`  in  4  ALU op (codes below)
- `ALUSrc_ex`  in  1  B operand = `imm_ex` when 1
- `Branch_ex`  in  1  conditional branch
- `funct3_ex`  in  3  branch condition
- `rd_ex`  in  5  destination register
- `RegWrite_ex`, `MemRead_ex`, `MemWrite_ex`, `MemtoReg_ex`, `valid_ex`  in  1 each  control bundle
- `wb_data`  in  XLEN  value being written back in WB
- `stall`  in  1  hold EX/MEM register
- `flush`  in  1  load bubble into EX/MEM
- `alu_result_mem`, `store_data_mem`  out  XLEN each  registered results
- `rd_mem`  out  5  registered destination
- `RegWrite_mem`, `MemRead_mem`, `MemWrite_mem`, `MemtoReg_mem`, `valid_mem`  out  1 each  registered control
- `branch_taken`  out  1  combinational; resolved branch taken
- `branch_target`  out  XLEN  combinational; `pc_ex + imm_ex`

## Operation
- Operand A = mux(`ForwardA`: 00 `rs1_data_ex`, 10 `alu_result_mem`, 01 `wb_data`).
- Forwarded B is built the same way from `rs2_data_ex`.
- ALU B = `ALUSrc_ex` ? `imm_ex` : forwarded B.
- `store_data` is always forwarded B, never the immediate.
- ALU codes:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU
  - 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND
  - any other code gives 0
- Shift amount is B[4:0]. SLT/SLTU return zero-extended 0/1. Add and sub wrap modulo 2^XLEN, with no overflow flag.
- Branch compare always uses forwarded A vs forwarded B, independent of `ALUSrc_ex`. `funct3_ex` selects:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU
  - 010 and 011 give not-taken
- `branch_taken` = `valid_ex & Branch_ex & cond`. `branch_target` wraps modulo 2^XLEN.
- EX/MEM register update, in priority order:
  1. `flush`: load a bubble (`valid_mem`=0, `RegWrite_mem`=0, `MemRead_mem`=0, `MemWrite_mem`=0; data fields don't-care but driven 0).
  2. Else `stall`: hold all fields.
  3. Else `valid_ex`=0: load a bubble.
  4. Else: load the ALU result, store data, `rd_ex` and the control bundle.
- A bubble never asserts `RegWrite_mem`. This lets the forwarding unit trust `RegWrite_mem` without checking `valid_mem`.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): all registered outputs = 0, so `valid_mem`=0 and no write or memory-access strobe is asserted.
- EX-to-MEM latency is one cycle. Operand muxes, ALU and branch logic are combinational within the cycle.
- MEM forwarding reads the current `alu_result_mem`, i.e. the previous instruction. During a stall the held value keeps being forwarded.
- Simultaneous `flush` and `stall`: flush wins.
- `branch_taken` is not gated by `stall`. The hazard unit must gate its use.
- Reset asserted mid-stall clears the register immediately. No state survives.

## Structure
- Shared package `riscv_pkg`:
  - ALU op codes (`ALU_ADD`, …) and branch `funct3` constants
  - forwarding select codes (`FWD_EX`=00, `FWD_MEM`=10, `FWD_WB`=01), shared with the forwarding unit
  - `XLEN` default
- One sub-module, `alu`: pure combinational `a`, `b`, `alu_ctrl` → `result`.
- The EX/MEM register and operand muxes stay in `ex_stage`.

## Test plan
- Reset: hold `rst_n`=0 with `valid_ex`=1 → all outputs 0. Release, apply ADD 5+7 (`rd_ex`=3) → next cycle `alu_result_mem`=12, `rd_mem`=3, `RegWrite_mem`=1, `valid_mem`=1.
- Forwarding:
  - Issue ADD x1=10+20, then SUB with `ForwardA`=10, `rs2_data_ex`=4 → `alu_result_mem`=26.
  - Repeat with `ForwardB`=01, `wb_data`=0xFFFF_FFFF, AND, A=0x0F0F → 0x0F0F.
- ALU edges:
  - SRA 0x8000_0000 by 31 → 0xFFFF_FFFF
  - SLT −1 vs 1 → 1; SLTU −1 vs 1 → 0
  - ADD 0xFFFF_FFFF+1 → 0
  - code 1111 → 0
- Branch: BLT with forwarded A=−5, B=3, `pc_ex`=0x100, `imm_ex`=0x20 → `branch_taken`=1, target 0x120. Same with `valid_ex`=0 → `branch_taken`=0.
- Stall/flush:
  - `stall`=1 for 3 cycles → outputs frozen.
  - `stall`=1 and `flush`=1 together → bubble loaded (`valid_mem`=0, `RegWrite_mem`=0).
  - `valid_ex`=0 without stall → bubble.
- Store path: `MemWrite_ex`=1, `ALUSrc_ex`=1, `imm_ex`=8, A=0x1000, `ForwardB`=10, `alu_result_mem`=0xABCD → `alu_result_mem`=0x1008, `store_data_mem`=0xABCD.
